// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory.
// Port 0 is the pipeline MEM stage, port 1 the interrupt/context-save engine.
// Wide (2*DATA_W) requests run as two back-to-back word accesses, high word first.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// WORD0 | first (or only) memory access at the latched address
// WORD1 | second access of a wide request at latched address + 1
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic                wide0,
  input  logic                wide1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [2*DATA_W-1:0] wdata0,
  input  logic [2*DATA_W-1:0] wdata1,
  output logic                done0,
  output logic                done1,
  output logic [2*DATA_W-1:0] rdata,
  output logic                busy,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic                wide_q, wide_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                win;
  logic                fin;

  // Winner of a request in IDLE: a tie goes to the port not granted last time.
  always_comb begin
    win = (req0 && req1) ? ~last_gnt_q : req1;
  end

  // State register and latched request fields; last_gnt resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hi_q       <= hi_d;
    end
  end

  // Next-state logic: grant in IDLE, sequence one or two words, always return to IDLE after done.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    wide_d     = wide_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hi_d       = hi_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = WORD0;
          gnt_d      = win;
          last_gnt_d = win;
          we_d       = win ? we1 : we0;
          wide_d     = win ? wide1 : wide0;
          addr_d     = win ? addr1 : addr0;
          wdata_d    = win ? wdata1 : wdata0;
        end
      end
      WORD0: begin
        if (wide_q) begin
          state_d = WORD1;
          if (!we_q) hi_d = mem_rdata;
        end else begin
          state_d = IDLE;
        end
      end
      WORD1: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state (plus mem_rdata for the read result), never on req.
  always_comb begin
    done0     = 1'b0;
    done1     = 1'b0;
    rdata     = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fin       = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      WORD0: begin
        mem_addr  = addr_q;
        mem_wdata = wide_q ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
        mem_read  = ~we_q;
        mem_write = we_q;
        fin       = ~wide_q;
      end
      WORD1: begin
        mem_addr  = addr_q + ADDR_W'(1);
        mem_wdata = wdata_q[DATA_W-1:0];
        mem_read  = ~we_q;
        mem_write = we_q;
        fin       = 1'b1;
      end
      default: ;
    endcase
    if (fin) begin
      done0 = ~gnt_q;
      done1 = gnt_q;
      if (!we_q) rdata = wide_q ? {hi_q, mem_rdata} : {{DATA_W{1'b0}}, mem_rdata};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts every output each cycle,
// directed scenarios pin the model with literal values, then random traffic runs.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, wide0 = 0, wide1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        done0, done1, busy, mem_read, mem_write;
  logic [31:0] rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .wide0(wide0), .wide1(wide1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Memory seen by the DUT.
  logic [15:0] sram [0:65535];
  assign mem_rdata = mem_read ? sram[mem_addr] : 16'h0000;
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_write) sram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state: the transaction in flight, a reference memory, and a log of completions.
  logic [15:0] ref_mem [0:65535];
  bit          m_act, m_port, m_we, m_wide, m_last;
  int          m_k;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  int          ndone [2];
  int          dcyc [2];
  logic [31:0] model_rdata [2];
  logic [31:0] dut_rdata [2];
  int          dlog_port [$];
  int          dlog_cyc [$];

  initial begin
    bit          e_busy, e_rd, e_wr, e_d0, e_d1, fin, w;
    logic [15:0] e_addr, e_wd, a2;
    logic [31:0] e_rdata;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    m_act = 0; m_last = 1; m_k = 0;
    ndone[0] = 0; ndone[1] = 0;
    forever begin
      @(negedge clk);
      e_busy = 0; e_rd = 0; e_wr = 0; e_d0 = 0; e_d1 = 0; fin = 0;
      e_addr = 0; e_wd = 0; e_rdata = 0;
      if (!rst_n) begin
        m_act = 0; m_last = 1;
      end else if (m_act) begin
        e_busy = 1;
        e_addr = m_addr + 16'(m_k - 1);
        e_rd = !m_we; e_wr = m_we;
        e_wd = (m_wide && m_k == 1) ? m_wdata[31:16] : m_wdata[15:0];
        fin = (m_k == (m_wide ? 2 : 1));
        if (fin) begin
          e_d0 = (m_port == 0); e_d1 = (m_port == 1);
          a2 = m_addr + 16'd1;
          if (!m_we) e_rdata = m_wide ? {ref_mem[m_addr], ref_mem[a2]} : {16'h0000, ref_mem[m_addr]};
        end
      end
      chk("busy", busy, e_busy);
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("done0", done0, e_d0);
      chk("done1", done1, e_d1);
      chk("rdata", rdata, e_rdata);
      chk("done_excl", done0 & done1, 0);
      if (rst_n) begin
        if (m_act) begin
          if (e_wr) ref_mem[e_addr] = e_wd;
          if (fin) begin
            m_act = 0;
            ndone[m_port] = ndone[m_port] + 1;
            dcyc[m_port] = cyc;
            model_rdata[m_port] = e_rdata;
            dut_rdata[m_port] = rdata;
            dlog_port.push_back(int'(m_port));
            dlog_cyc.push_back(cyc);
          end else begin
            m_k++;
          end
        end else if (req0 || req1) begin
          w = (req0 && req1) ? !m_last : req1;
          m_last = w; m_port = w;
          m_we = w ? we1 : we0;
          m_wide = w ? wide1 : wide0;
          m_addr = w ? addr1 : addr0;
          m_wdata = w ? wdata1 : wdata0;
          m_act = 1; m_k = 1;
        end
      end
    end
  end

  task automatic set_port(input int p, input bit r, input bit we, input bit wide,
                          input logic [15:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = we; wide0 = wide; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = we; wide1 = wide; addr1 = a; wdata1 = d; end
  endtask

  task automatic wait_done(input int p, input int n0, output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = (ndone[p] != n0);
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic run_req(input int p, input bit we, input bit wide,
                         input logic [15:0] a, input logic [31:0] d);
    int n0, c0;
    bit got;
    n0 = ndone[p]; c0 = cyc;
    set_port(p, 1, we, wide, a, d);
    wait_done(p, n0, got);
    set_port(p, 0, 0, 0, 16'h0, 32'h0);
    if (got) chk("latency", dcyc[p] - c0, wide ? 2 : 1);
  endtask

  task automatic rand_req(input int p);
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    a = (r < 8) ? 16'(r) : ((r == 8) ? 16'hFFFF : 16'hFFFE);
    set_port(p, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int  n0, n1, c0, base;
    bit  got;
    bit  rv [2];
    int  seen [2];

    repeat (3) @(posedge clk);
    #1;
    zero_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Narrow write then read back.
    run_req(0, 1, 0, 16'h0001, 32'h0000A05F);
    chk("nw_mem", sram[16'h0001], 16'hA05F);
    run_req(0, 0, 0, 16'h0001, 32'h0);
    chk("nr_rdata", dut_rdata[0], 32'h0000A05F);
    chk("nr_model", model_rdata[0], 32'h0000A05F);

    // Wide write then wide read.
    run_req(1, 1, 1, 16'h0010, 32'h12345678);
    chk("ww_hi", sram[16'h0010], 16'h1234);
    chk("ww_lo", sram[16'h0011], 16'h5678);
    run_req(1, 0, 1, 16'h0010, 32'h0);
    chk("wr_rdata", dut_rdata[1], 32'h12345678);
    chk("wr_model", model_rdata[1], 32'h12345678);

    // Wrap-around of the second word address.
    run_req(1, 1, 1, 16'hFFFF, 32'hCAFEBEEF);
    chk("wrap_hi", sram[16'hFFFF], 16'hCAFE);
    chk("wrap_lo", sram[16'h0000], 16'hBEEF);
    run_req(0, 0, 0, 16'h0000, 32'h0);
    chk("wrap_rd", dut_rdata[0], 32'h0000BEEF);

    // Late request during port 1's wide WORD0.
    n0 = ndone[0]; n1 = ndone[1]; c0 = cyc;
    set_port(1, 1, 0, 1, 16'h0010, 32'h0);
    @(posedge clk); #1;
    set_port(0, 1, 0, 0, 16'h0001, 32'h0);
    wait_done(1, n1, got);
    set_port(1, 0, 0, 0, 16'h0, 32'h0);
    wait_done(0, n0, got);
    set_port(0, 0, 0, 0, 16'h0, 32'h0);
    chk("late_done1", dcyc[1] - c0, 2);
    chk("late_done0", dcyc[0] - c0, 4);
    chk("late_rd1", dut_rdata[1], 32'h12345678);
    chk("late_rd0", dut_rdata[0], 32'h0000A05F);

    // Reset in WORD1 of a wide write.
    run_req(0, 1, 0, 16'h0021, 32'h00001111);
    n0 = ndone[0];
    set_port(0, 1, 1, 1, 16'h0020, 32'hAAAA5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_w1_addr", mem_addr, 16'h0021);
    chk("mr_w1_write", mem_write, 1);
    rst_n = 0;
    set_port(0, 0, 0, 0, 16'h0, 32'h0);
    #1;
    zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("mr_hi_kept", sram[16'h0020], 16'hAAAA);
    chk("mr_lo_old", sram[16'h0021], 16'h1111);
    chk("mr_no_done", ndone[0], n0);

    // Contention from reset: both narrow reads held high.
    set_port(0, 1, 0, 0, 16'h0010, 32'h0);
    set_port(1, 1, 0, 0, 16'h0011, 32'h0);
    base = dlog_port.size();
    c0 = cyc;
    rst_n = 1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      got = (dlog_port.size() >= base + 4);
    end
    set_port(0, 0, 0, 0, 16'h0, 32'h0);
    set_port(1, 0, 0, 0, 16'h0, 32'h0);
    chk("cont_timeout", got, 1);
    if (got) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_port", dlog_port[base + i], i % 2);
        chk("cont_cyc", dlog_cyc[base + i] - c0, 2 * i + 1);
      end
    end
    @(posedge clk); #1;

    // Random traffic: requests held until their done, then dropped or replaced.
    rv[0] = 0; rv[1] = 0;
    seen[0] = ndone[0]; seen[1] = ndone[1];
    repeat (3000) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) begin
          if (ndone[p] != seen[p]) begin
            seen[p] = ndone[p];
            rv[p] = ($urandom_range(0, 3) != 0);
            if (rv[p]) rand_req(p);
            else set_port(p, 0, 0, 0, 16'h0, 32'h0);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rv[p] = 1;
          rand_req(p);
        end
      end
    end
    repeat (10) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && ndone[p] != seen[p]) begin
          rv[p] = 0;
          set_port(p, 0, 0, 0, 16'h0, 32'h0);
        end
      end
    end
    chk("drain", {30'h0, rv[1], rv[0]}, 0);
    set_port(0, 0, 0, 0, 16'h0, 32'h0);
    set_port(1, 0, 0, 0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    zero_outputs("end_idle");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
